disp_scan_buf: RTL and testbench
================================

Name: disp_scan_buf

Overview:
- Source side of the 8-digit seven-segment display path, feeding the display multiplexer.
- Accepts decoded character codes from the Morse decoder over a valid/ready handshake and keeps them in an 8-character scrolling buffer.
- Encodes the buffer into active-low segment patterns and drives them on the 64-bit seg_data bus.
- Generates the rotating one-cold an_sel digit-scan strobe at the refresh rate.

Parameters:
- SCAN_DIV, 10000, clk_10Mhz cycles per digit dwell (1 kHz per digit); must be >= 2.
- NUM_DIGITS, 8, number of digits; fixed at 8, must not be overridden.

Ports:
- clk_10Mhz  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- char_valid  input  1  upstream has a character on char_code.
- char_code  input  6  character code: 0-9 = digits '0'-'9'; 10-35 = 'A'-'Z'; 6'h3E = backspace; 6'h3F = space; all other codes are unmapped.
- char_ready  output  1  block can accept a character this cycle.
- clear  input  1  synchronous blank of the whole buffer.
- seg_data  output  64  byte k = active-low pattern for digit k. Bit0 = segment A through bit6 = segment G; bit7 = DP, always 1.
- an_sel  output  8  one-cold digit select; bit k low = digit k active.

Behaviour:
- Reset (reset_n = 0 at an edge):
  - buffer all blank; seg_data = 64'hFFFF_FFFF_FFFF_FFFF;
  - an_sel = 8'hFE;
  - scan counter = 0; char_ready = 1; pending register empty.
- Handshake:
  - A transfer occurs on an edge where char_valid & char_ready are both 1.
  - The code is captured into the pending register.
  - char_ready is 0 for exactly the next cycle, the shift cycle, then returns to 1.
  - Sustained throughput is one character per 2 cycles.
  - Upstream holds char_valid/char_code stable while char_ready = 0.
- Shift cycle, applied at the edge following the transfer:
  - Normal code: digit7 <- digit6 <- ... <- digit1 <- digit0 <- new code. The oldest character in digit7 is discarded.
  - Backspace: digit0 <- digit1 <- ... <- digit6 <- digit7 <- blank.
  - Space: shifted in as blank.
- Encoding:
  - seg_data is registered from the buffer through a lookup.
  - The new pattern is visible 2 edges after the transfer edge.
  - Required patterns:
    - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8, 8:80, 9:90
    - A:88, b:83, C:C6, d:A1, E:86, F:8E
    - blank:FF
    - unmapped codes: BF (dash, G only)
  - Remaining letters G-Z use the package table.
- clear:
  - At an edge with clear = 1, all buffer entries go blank and the pending register is emptied.
  - seg_data reads all FF one edge later.
  - clear coincident with a transfer: the transfer completes (char_ready low the next cycle) but the character is discarded.
  - clear coincident with a shift cycle: clear wins.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1 and wraps.
  - At the edge where the counter is SCAN_DIV-1, an_sel rotates left one place: FE -> FD -> FB -> F7 -> EF -> DF -> BF -> 7F -> FE.
  - an_sel is always exactly one-cold.
  - Scanning is independent of the handshake and of clear.
- Reset mid-operation: a pending character is dropped, and everything returns to its reset values on that edge.
- Counter width: $clog2(SCAN_DIV). No overflow is permitted, since the counter wraps explicitly.

Decomposition:
- Package disp_pkg holds:
  - the char_code constants (CHAR_BKSP = 6'h3E, CHAR_SPACE = 6'h3F);
  - SEG_BLANK = 8'hFF and SEG_DASH = 8'hBF;
  - the 64-entry encode table as a constant array.
- One sub-module, seg_encode: purely combinational, 6-bit code in, 8-bit pattern out. It is instantiated 8 times.

Test Plan:
- Reset check: hold reset_n = 0 for 3 cycles, then release. Expect:
  - seg_data = all FF, an_sel = FE, char_ready = 1;
  - with SCAN_DIV = 4, an_sel = FD after 4 edges and back to FE after 32 edges.
- Send code 1, then 2, then 3 via the handshake. Expect:
  - char_ready low for 1 cycle after each transfer;
  - final seg_data[23:0] = 24'hF9A4B0, with upper bytes FF.
- Send 9 digits 0-8. Expect:
  - digit7 = F9 ('1'), digit0 = 80 ('8');
  - '0' has been discarded.
- Send A, b, then backspace. Expect:
  - seg_data[7:0] = 88 and seg_data[15:8] = FF.
- Send code 6'h30 (unmapped). Expect seg_data[7:0] = BF.
- Assert clear together with a transfer of code 5. Expect:
  - seg_data = all FF;
  - char_ready = 0 on the next cycle;
  - an_sel continues rotating undisturbed.

Source files
------------

// File: rtl/disp_scan_buf_pkg.sv
// Shared types and constants for the seven-segment source path.
// Also holds the active-low segment lookup table, indexed by character code.
package disp_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [5:0] CHAR_BKSP  = 6'h3E;
  localparam logic [5:0] CHAR_SPACE = 6'h3F;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic {
    ST_ACCEPT,
    ST_SHIFT
  } hs_state_e;

  // Bit0 = segment A ... bit6 = segment G, bit7 = DP (always off).
  // Buffer slots hold CHAR_SPACE when blank, so entry 63 doubles as the blank pattern.
  localparam logic [7:0] SEG_TABLE [64] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E,
    8'hC2, 8'h89, 8'hCF, 8'hE1, 8'h8A, 8'hC7, 8'hEA, 8'hAB,
    8'hA3, 8'h8C, 8'h98, 8'hAF, 8'h92, 8'h87, 8'hC1, 8'hE3,
    8'hD5, 8'h89, 8'h91, 8'hA4, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_BLANK
  };

endpackage

// File: rtl/disp_scan_buf_if.sv
// Character handshake plus display outputs between the decoder, this block and the mux.
interface disp_scan_buf_if;

  logic        char_valid;
  logic [5:0]  char_code;
  logic        char_ready;
  logic        clear;
  logic [63:0] seg_data;
  logic [7:0]  an_sel;

  modport master (
    output char_valid,
    output char_code,
    output clear,
    input  char_ready,
    input  seg_data,
    input  an_sel
  );

  modport slave (
    input  char_valid,
    input  char_code,
    input  clear,
    output char_ready,
    output seg_data,
    output an_sel
  );

endinterface

// File: rtl/disp_scan_buf_seg_encode.sv
// Combinational character-code to active-low segment pattern lookup.
module seg_encode
  import disp_pkg::*;
(
  input  logic [5:0] code,
  output logic [7:0] seg
);

  assign seg = SEG_TABLE[code];

endmodule

// File: rtl/disp_scan_buf.sv
// Eight-character scrolling buffer with handshake input, registered segment encode
// and a rotating one-cold digit scan strobe.
module disp_scan_buf
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 10000
) (
  input  logic          clk_10Mhz,
  input  logic          reset_n,
  disp_scan_buf_if.slave disp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  hs_state_e state_q;
  hs_state_e state_nxt;
  logic      ready_c;
  logic      xfer;

  logic       pending_vld;
  logic [5:0] pending_code;

  logic [5:0] digit_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0][7:0] enc;
  logic [63:0] seg_q;

  logic [CW-1:0] scan_cnt;
  logic [7:0]    an_q;

  always_ff @(posedge clk_10Mhz) begin
    if (!reset_n) begin
      state_q <= ST_ACCEPT;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Every accepted character costs one blocked cycle while it is shifted in.
  always_comb begin
    state_nxt = state_q;
    ready_c   = 1'b0;
    case (state_q)
      ST_ACCEPT: begin
        ready_c = 1'b1;
        if (disp.char_valid) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        state_nxt = ST_ACCEPT;
      end
      default: begin
        state_nxt = ST_ACCEPT;
      end
    endcase
  end

  assign xfer            = ready_c & disp.char_valid;
  assign disp.char_ready = ready_c;

  always_ff @(posedge clk_10Mhz) begin
    if (!reset_n) begin
      pending_vld  <= 1'b0;
      pending_code <= CHAR_SPACE;
    end else if (disp.clear) begin
      pending_vld  <= 1'b0;
    end else if (xfer) begin
      pending_vld  <= 1'b1;
      pending_code <= disp.char_code;
    end else if (state_q == ST_SHIFT) begin
      pending_vld  <= 1'b0;
    end
  end

  // Blank slots hold CHAR_SPACE, so a space needs no special handling here.
  always_ff @(posedge clk_10Mhz) begin
    if (!reset_n || disp.clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_q[i] <= CHAR_SPACE;
      end
    end else if (state_q == ST_SHIFT && pending_vld) begin
      if (pending_code == CHAR_BKSP) begin
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
          digit_q[i] <= digit_q[i+1];
        end
        digit_q[NUM_DIGITS-1] <= CHAR_SPACE;
      end else begin
        for (int i = 1; i < NUM_DIGITS; i++) begin
          digit_q[i] <= digit_q[i-1];
        end
        digit_q[0] <= pending_code;
      end
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_enc
    seg_encode u_seg_encode (
      .code (digit_q[k]),
      .seg  (enc[k])
    );
  end

  always_ff @(posedge clk_10Mhz) begin
    if (!reset_n) begin
      seg_q <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      seg_q <= enc;
    end
  end

  assign disp.seg_data = seg_q;

  // Free-running digit scan, deliberately untouched by clear and the handshake.
  always_ff @(posedge clk_10Mhz) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      an_q     <= 8'hFE;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      an_q     <= {an_q[6:0], an_q[7]};
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  assign disp.an_sel = an_q;

endmodule

// File: tb/tb_disp_scan_buf.sv
// Directed bench for disp_scan_buf with SCAN_DIV = 4 and hand-computed expectations.
module tb_disp_scan_buf;

  localparam int SCAN_DIV = 4;

  logic clk_10Mhz;
  logic reset_n;
  int   total;
  int   bad;
  int   edge_cnt;

  disp_scan_buf_if bus ();

  disp_scan_buf #(
    .SCAN_DIV (SCAN_DIV)
  ) u_dut (
    .clk_10Mhz (clk_10Mhz),
    .reset_n   (reset_n),
    .disp      (bus)
  );

  initial clk_10Mhz = 1'b0;
  always #5 clk_10Mhz = ~clk_10Mhz;

  // Reference for the scan strobe: edges since the last reset edge.
  always @(posedge clk_10Mhz) begin
    if (!reset_n) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;
  end

  function automatic logic [7:0] expAn(input int n);
    logic [7:0] a;
    a = 8'hFE;
    for (int i = 0; i < (n / SCAN_DIV) % 8; i++) a = {a[6:0], a[7]};
    return a;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_10Mhz);
    #1;
  endtask

  // One handshake transfer; optional clear on the transfer edge or the shift edge.
  task automatic applyStimulus(input logic [5:0] code, input logic clr_xfer, input logic clr_shift);
    int n;
    n = 0;
    while (!bus.char_ready && n < 10) begin
      tick();
      n++;
    end
    if (n >= 10) checkOutput("ready_timeout", 64'(bus.char_ready), 64'd1);
    bus.char_valid = 1'b1;
    bus.char_code  = code;
    bus.clear      = clr_xfer;
    tick();
    checkOutput("ready_low", 64'(bus.char_ready), 64'd0);
    bus.clear = clr_shift;
    tick();
    bus.char_valid = 1'b0;
    bus.clear      = 1'b0;
    checkOutput("ready_back", 64'(bus.char_ready), 64'd1);
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset_n        = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_code  = 6'd0;
    bus.clear      = 1'b0;

    repeat (3) tick();
    checkOutput("rst_seg", bus.seg_data, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("rst_an", 64'(bus.an_sel), 64'hFE);
    checkOutput("rst_ready", 64'(bus.char_ready), 64'd1);
    reset_n = 1'b1;

    repeat (4) tick();
    checkOutput("scan_fd", 64'(bus.an_sel), 64'hFD);
    repeat (28) tick();
    checkOutput("scan_wrap", 64'(bus.an_sel), 64'hFE);

    applyStimulus(6'd1, 1'b0, 1'b0);
    applyStimulus(6'd2, 1'b0, 1'b0);
    applyStimulus(6'd3, 1'b0, 1'b0);
    tick();
    checkOutput("seq123", bus.seg_data, 64'hFFFF_FFFF_FFF9_A4B0);
    checkOutput("scan_a", 64'(bus.an_sel), 64'(expAn(edge_cnt)));

    for (int i = 0; i < 9; i++) applyStimulus(6'(i), 1'b0, 1'b0);
    tick();
    checkOutput("nine_digits", bus.seg_data, 64'hF9A4_B099_9282_F880);

    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    tick();
    checkOutput("clear_only", bus.seg_data, 64'hFFFF_FFFF_FFFF_FFFF);

    applyStimulus(6'd10, 1'b0, 1'b0);
    applyStimulus(6'd11, 1'b0, 1'b0);
    applyStimulus(6'h3E, 1'b0, 1'b0);
    tick();
    checkOutput("backspace", bus.seg_data, 64'hFFFF_FFFF_FFFF_FF88);

    applyStimulus(6'h30, 1'b0, 1'b0);
    tick();
    checkOutput("unmapped", bus.seg_data, 64'hFFFF_FFFF_FFFF_88BF);
    applyStimulus(6'h3F, 1'b0, 1'b0);
    applyStimulus(6'd17, 1'b0, 1'b0);
    tick();
    checkOutput("space_h", bus.seg_data, 64'hFFFF_FFFF_88BF_FF89);

    applyStimulus(6'd5, 1'b1, 1'b0);
    checkOutput("clr_xfer_seg", bus.seg_data, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    checkOutput("clr_xfer_drop", bus.seg_data, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("scan_b", 64'(bus.an_sel), 64'(expAn(edge_cnt)));

    applyStimulus(6'd7, 1'b0, 1'b0);
    tick();
    checkOutput("pre_shift_clr", bus.seg_data, 64'hFFFF_FFFF_FFFF_FFF8);
    applyStimulus(6'd8, 1'b0, 1'b1);
    tick();
    checkOutput("clr_shift", bus.seg_data, 64'hFFFF_FFFF_FFFF_FFFF);

    applyStimulus(6'd9, 1'b0, 1'b0);
    bus.char_valid = 1'b1;
    bus.char_code  = 6'd4;
    tick();
    bus.char_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    checkOutput("rst_mid_ready", 64'(bus.char_ready), 64'd1);
    checkOutput("rst_mid_seg", bus.seg_data, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("rst_mid_an", 64'(bus.an_sel), 64'hFE);
    reset_n = 1'b1;
    repeat (2) tick();
    checkOutput("rst_mid_drop", bus.seg_data, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (9) tick();
    checkOutput("scan_c", 64'(bus.an_sel), 64'(expAn(edge_cnt)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
